// File: rtl/scan_decoder.sv
// One-hot decoder whose index is either held or auto-scanned; SCAN_DECODER_PRESCALE_EN builds a DIV-cycle step prescaler.
// Latency: load and mode changes show on d/idx one edge later; scan steps every DIV cycles (every cycle without the prescaler).
// Backpressure: none, the outputs are free-running registers and load is a single-cycle strobe.
module scan_decoder #(
    parameter int N   = 3,
    parameter int DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              load,
    input  logic [N-1:0]      a,
    output logic [(1<<N)-1:0] d,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int M = 1 << N;

    if (N < 1 || N > 6) begin : g_bad_n
        $error("scan_decoder: N must be in 1..6");
    end
    if (DIV < 1 || DIV > 65535) begin : g_bad_div
        $error("scan_decoder: DIV must be in 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [M-1:0]   d_q, d_d;
    logic           wrap_q, wrap_d;
    logic           scan_stay;
    logic           step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = mode ? ST_SCAN : ST_HOLD;
            end
            ST_HOLD: begin
                if (!en)      state_d = ST_IDLE;
                else if (mode) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (!en)       state_d = ST_IDLE;
                else if (!mode) state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stepping only happens while SCAN is kept; entering or leaving SCAN never steps.
    assign scan_stay = (state_q == ST_SCAN) && (state_d == ST_SCAN);

`ifdef SCAN_DECODER_PRESCALE_EN
    localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_q, pre_d;

    // Any cycle that is not a continued scan (entry, load, hold, idle) restarts the count.
    always_comb begin
        pre_d = '0;
        if (scan_stay && !load) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign step = scan_stay && !load && (pre_q == PRE_LAST);
`else
    assign step = scan_stay && !load;
`endif

    // Load wins over a coincident step and suppresses the wrap pulse.
    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (en && load) begin
            idx_d = a;
        end else if (step) begin
            idx_d  = idx_q + N'(1);
            wrap_d = (idx_q == {N{1'b1}});
        end
        d_d = (state_d == ST_IDLE) ? '0 : (M'(1) << idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            d_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            d_q    <= d_d;
            wrap_q <= wrap_d;
        end
    end

    assign d    = d_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

    a_idle_dark: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_IDLE) |-> (d_q == '0));
    a_active_onehot: assert property (@(posedge clk) disable iff (rst)
        (state_q != ST_IDLE) |-> (d_q == (M'(1) << idx_q)));
    a_wrap_at_zero: assert property (@(posedge clk) disable iff (rst)
        wrap_q |-> ((idx_q == '0) && (state_q == ST_SCAN)));

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: reset, direct-decode table, scan/wrap, load collision, enable drop, random vs. model.
module tb_scan_decoder;

    localparam int N   = 3;
    localparam int DIV = 4;
    localparam int M   = 1 << N;
`ifdef SCAN_DECODER_PRESCALE_EN
    localparam int STEP = DIV;
`else
    localparam int STEP = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         mode;
    logic         load;
    logic [N-1:0] a;
    logic [M-1:0] d;
    logic [N-1:0] idx;
    logic         wrap;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: "lit" flag, "scanning" flag, index and cycles since the last step.
    bit m_active;
    bit m_scan;
    int m_idx;
    int m_cnt;
    bit m_wrap;

    typedef struct {
        logic [N-1:0] a;
        logic [M-1:0] d;
    } vec_t;
    vec_t tbl[M];

    scan_decoder #(.N(N), .DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .load (load),
        .a    (a),
        .d    (d),
        .idx  (idx),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [M-1:0] ed, input logic [N-1:0] ei, input logic ew);
        n_chk++;
        if (d === ed && idx === ei && wrap === ew) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got d=%h idx=%0d wrap=%b, expected d=%h idx=%0d wrap=%b",
                     name, d, idx, wrap, ed, ei, ew);
        end
    endtask

    task automatic cyc(input logic e, input logic m, input logic l, input logic [N-1:0] av);
        en   = e;
        mode = m;
        load = l;
        a    = av;
        @(negedge clk);
    endtask

    task automatic m_reset();
        m_active = 1'b0;
        m_scan   = 1'b0;
        m_idx    = 0;
        m_cnt    = 0;
        m_wrap   = 1'b0;
    endtask

    task automatic m_step();
        bit stay;
        m_wrap = 1'b0;
        if (!en) begin
            m_active = 1'b0;
            m_scan   = 1'b0;
        end else begin
            stay = m_scan && mode;
            if (load) begin
                m_idx = int'(a);
                m_cnt = 0;
            end else if (stay) begin
                m_cnt++;
                if (m_cnt == STEP) begin
                    m_cnt  = 0;
                    m_idx  = (m_idx + 1) % M;
                    m_wrap = (m_idx == 0);
                end
            end else begin
                m_cnt = 0;
            end
            m_active = 1'b1;
            m_scan   = mode;
        end
    endtask

    function automatic logic [M-1:0] m_d();
        return m_active ? (M'(1) << m_idx) : '0;
    endfunction

    initial begin
        logic [N-1:0] after_wrap_idx;
        rst  = 1'b1;
        en   = 1'b0;
        mode = 1'b0;
        load = 1'b0;
        a    = '0;
        @(negedge clk);
        chk("reset", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;

        // Direct decode: each load shows one edge later.
        for (int i = 0; i < M; i++) begin
            tbl[i].a = N'(i);
        end
        tbl[0].d = 8'h01; tbl[1].d = 8'h02; tbl[2].d = 8'h04; tbl[3].d = 8'h08;
        tbl[4].d = 8'h10; tbl[5].d = 8'h20; tbl[6].d = 8'h40; tbl[7].d = 8'h80;
        for (int i = 0; i < M; i++) begin
            cyc(1'b1, 1'b0, 1'b1, tbl[i].a);
            chk("direct", tbl[i].d, tbl[i].a, 1'b0);
        end
        cyc(1'b1, 1'b0, 1'b0, 3'd0);
        chk("hold", 8'h80, 3'd7, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 3'd0);
        chk("idle_dark", 8'h00, 3'd7, 1'b0);

        // Scan from 6 through the wrap.
        cyc(1'b1, 1'b0, 1'b1, 3'd6);
        chk("scan_load6", 8'h40, 3'd6, 1'b0);
        for (int k = 0; k < STEP; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 3'd0);
            chk("scan_at6", 8'h40, 3'd6, 1'b0);
        end
        for (int k = 0; k < STEP; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 3'd0);
            chk("scan_at7", 8'h80, 3'd7, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        chk("scan_wrap", 8'h01, 3'd0, 1'b1);
        after_wrap_idx = (STEP > 1) ? 3'd0 : 3'd1;
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        chk("wrap_once", M'(1) << after_wrap_idx, after_wrap_idx, 1'b0);

        // Load coinciding with the terminal prescale cycle.
        cyc(1'b1, 1'b1, 1'b1, 3'd7);
        chk("col_load7", 8'h80, 3'd7, 1'b0);
        for (int k = 0; k < STEP - 1; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 3'd0);
            chk("col_wait", 8'h80, 3'd7, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b1, 3'd2);
        chk("col_load2", 8'h04, 3'd2, 1'b0);
        for (int k = 0; k < STEP - 1; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 3'd0);
            chk("col_hold2", 8'h04, 3'd2, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        chk("col_next", 8'h08, 3'd3, 1'b0);

        // Enable drop during scan: outputs dark, index kept, load ignored.
        cyc(1'b1, 1'b1, 1'b1, 3'd3);
        chk("drop_load3", 8'h08, 3'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 1'b1, 3'd6);
            chk("en_drop", 8'h00, 3'd3, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        chk("en_back", 8'h08, 3'd3, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        cyc(1'b1, 1'b1, 1'b1, 3'd5);
        chk("pre_rst_idx5", 8'h20, 3'd5, 1'b0);
        #2 rst = 1'b1;
        #1 chk("async_rst", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        chk("rst_held", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        chk("rst_resume", 8'h01, 3'd0, 1'b0);

        // Full walk from idx 0 on SCAN entry.
        cyc(1'b0, 1'b0, 1'b0, 3'd0);
        chk("walk_idle", 8'h00, 3'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 3'd0);
        for (int k = 0; k <= M * STEP; k++) begin
            chk("walk", M'(1) << ((k / STEP) % M), N'((k / STEP) % M), (k == M * STEP));
            cyc(1'b1, 1'b1, 1'b0, 3'd0);
        end

        // Randomized traffic against the model.
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < 600; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            load = ($urandom_range(0, 5) == 0);
            a    = N'($urandom_range(0, M - 1));
            if ($urandom_range(0, 59) == 0) begin
                #2 rst = 1'b1;
                m_reset();
                #1 chk("rand_rst", m_d(), N'(m_idx), m_wrap);
                @(negedge clk);
                rst = 1'b0;
            end else begin
                @(posedge clk);
                m_step();
                @(negedge clk);
                chk("random", m_d(), N'(m_idx), m_wrap);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter N, default 3: select width; outputs 2**N one-hot lines; legal range 1..6.
REQ-002 SHALL have parameter DIV, default 4: clock cycles per scan step; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  enable; 0 forces all decode outputs low.
REQ-006 SHALL have port mode  input  1  0 = direct (hold) decode, 1 = auto-scan.
REQ-007 SHALL have port load  input  1  single-cycle strobe capturing a into the index register.
REQ-008 SHALL have port a  input  N  select value captured on load.
REQ-009 SHALL have port d  output  2**N  registered one-hot decode of current index; D[i] high iff index == i and block active.
REQ-010 SHALL have port idx  output  N  registered current index.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on scan wrap from 2**N-1 to 0.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, HOLD, SCAN.
REQ-013 SHALL transition from any state to IDLE on the next edge when en=0.
REQ-014 SHALL transition from IDLE or SCAN to HOLD on the next edge when en=1 and mode=0.
REQ-015 SHALL transition from IDLE or HOLD to SCAN on the next edge when en=1 and mode=1.
REQ-016 SHALL drive d to all-zero whenever the registered state is IDLE.
REQ-017 SHALL drive d to exactly one bit high, bit idx, in HOLD and SCAN; d and idx always update together.
REQ-018 SHALL, on load=1 with en=1, set idx to a on the next edge; d reflects the new value at the same edge (latency 1 cycle).
REQ-019 SHALL ignore load when en=0; idx retains its value through IDLE.
REQ-020 SHALL hold idx constant in HOLD apart from load.
REQ-021 SHALL, in SCAN, run a prescale counter 0..DIV-1 and increment idx by 1 on the edge after terminal count DIV-1.
REQ-022 SHALL wrap idx from 2**N-1 to 0, asserting wrap for exactly the cycle in which idx=0 and d[0]=1 are first registered.
REQ-023 SHALL give load priority over a coincident scan step: idx becomes a, prescaler clears to 0, no wrap pulse.
REQ-024 SHALL clear the prescale counter on every entry into SCAN, so the first step occurs DIV cycles after entry.
REQ-025 SHALL keep wrap low outside SCAN and whenever a load occurs.

Reset
REQ-026 SHALL, while rst=1, immediately force state=IDLE, idx=0, d=0, wrap=0, prescaler=0, independent of clk.
REQ-027 SHALL, on rst deassertion mid-scan, resume from IDLE with idx=0; SCAN is entered only on a subsequent edge with en=1, mode=1.

Configuration
REQ-028 SHALL provide macro SCAN_DECODER_PRESCALE_EN: when defined, the prescaler of REQ-021 is built and steps occur every DIV cycles.
REQ-029 SHALL, when SCAN_DECODER_PRESCALE_EN is undefined, omit the prescaler, ignore DIV, and step idx on every clock in SCAN; all other behaviour unchanged.

Verification (N=3, DIV=4, macro defined unless noted)
REQ-030 SHALL cover reset: rst=1 mid-scan with idx=5 -> d=8'h00, idx=0, wrap=0 without a clock edge.
REQ-031 SHALL cover direct decode: en=1, mode=0, load with a=0..7 in turn -> one edge later d=8'h01,02,04,...,80 and idx=a.
REQ-032 SHALL cover scan: en=1, mode=1 from idx=6 -> d=8'h40 for 4 cycles, 8'h80 for 4 cycles, then 8'h01 with wrap=1 for exactly one cycle.
REQ-033 SHALL cover load/step collision: load with a=2 on the terminal prescale cycle at idx=7 -> idx=2, d=8'h04, wrap=0; next step 4 cycles later.
REQ-034 SHALL cover enable drop: en=0 for 3 cycles during SCAN at idx=3 -> d=8'h00, idx stays 3, load ignored; en=1 restores d=8'h08.
REQ-035 SHALL cover macro undefined: SCAN entered at idx=0 -> d walks 01,02,04,...,80,01 on consecutive cycles, wrap high with the second 01.
